// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode seven-segment display.
// Drives one digit per slot from a per-frame snapshot of VALUE/CTRL.
module seg_scan_ctrl #(
    parameter int unsigned DIV = 50000,
    parameter int unsigned GAP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        re,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n
);

    localparam int unsigned CNT_MAX = (DIV > GAP) ? DIV : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [0:0] S_BLANK = 1'b0;
    localparam logic [0:0] S_DRIVE = 1'b1;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // CPU-visible registers; CTRL is kept as its three live fields only
    logic [31:0]   r_value;
    logic [7:0]    r_en_mask;
    logic          r_lz_blank;
    logic [7:0]    r_dp_mask;
    logic [31:0]   r_rdata;

    // Per-frame shadows used by the scan path
    logic [31:0]   r_sh_value;
    logic [7:0]    r_sh_en_mask;
    logic          r_sh_lz_blank;
    logic [7:0]    r_sh_dp_mask;

    logic [0:0]    r_state;
    logic [2:0]    r_idx;
    logic [CW-1:0] r_cnt;

    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp_n;

    logic [0:0]    w_state_nxt;
    logic [2:0]    w_idx_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_eff;
    logic          w_last;
    logic          w_snap;

    logic [31:0]   w_val_src;
    logic [7:0]    w_en_src;
    logic          w_lz_src;
    logic [7:0]    w_dp_src;
    logic [7:0]    w_nz_from;
    logic [3:0]    w_nib;
    logic          w_lit;

    logic [7:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_n_nxt;

    logic [31:0]   w_ctrl_rd;

    function automatic logic [6:0] hex_code(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h3F;
            4'h1: c = 7'h06;
            4'h2: c = 7'h5B;
            4'h3: c = 7'h4F;
            4'h4: c = 7'h66;
            4'h5: c = 7'h6D;
            4'h6: c = 7'h7D;
            4'h7: c = 7'h07;
            4'h8: c = 7'h7F;
            4'h9: c = 7'h6F;
            4'hA: c = 7'h77;
            4'hB: c = 7'h7C;
            4'hC: c = 7'h39;
            4'hD: c = 7'h5E;
            4'hE: c = 7'h79;
            default: c = 7'h71;
        endcase
        return c;
    endfunction

    assign w_ctrl_rd = {8'h00, r_dp_mask, 7'h00, r_lz_blank, r_en_mask};

    // Register file; a read in the same cycle as a write returns the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value    <= '0;
            r_en_mask  <= 8'hFF;
            r_lz_blank <= 1'b0;
            r_dp_mask  <= '0;
            r_rdata    <= '0;
        end else begin
            if (we) begin
                if (addr) begin
                    r_en_mask  <= wdata[7:0];
                    r_lz_blank <= wdata[8];
                    r_dp_mask  <= wdata[23:16];
                end else begin
                    r_value <= wdata;
                end
            end
            if (re) begin
                r_rdata <= addr ? w_ctrl_rd : r_value;
            end
        end
    end

    // A zero counter in BLANK only occurs right after reset; it stands for a full gap
    assign w_cnt_eff = ((r_state == S_BLANK) && (r_cnt == '0)) ? CW'(GAP) : r_cnt;
    assign w_last    = (w_cnt_eff <= CW'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = w_cnt_eff - CW'(1);
        w_snap      = 1'b0;
        case (r_state)
            S_BLANK: begin
                if (w_last) begin
                    w_state_nxt = S_DRIVE;
                    w_idx_nxt   = r_idx + 3'd1;
                    w_cnt_nxt   = CW'(DIV);
                    w_snap      = (r_idx == 3'd7);
                end
            end
            default: begin
                if (w_last) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = CW'(GAP);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BLANK;
            r_idx   <= 3'd7;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_value    <= '0;
            r_sh_en_mask  <= 8'hFF;
            r_sh_lz_blank <= 1'b0;
            r_sh_dp_mask  <= '0;
        end else if (w_snap) begin
            r_sh_value    <= r_value;
            r_sh_en_mask  <= r_en_mask;
            r_sh_lz_blank <= r_lz_blank;
            r_sh_dp_mask  <= r_dp_mask;
        end
    end

    // The digit being entered at a frame start must see the snapshot being taken
    assign w_val_src = w_snap ? r_value    : r_sh_value;
    assign w_en_src  = w_snap ? r_en_mask  : r_sh_en_mask;
    assign w_lz_src  = w_snap ? r_lz_blank : r_sh_lz_blank;
    assign w_dp_src  = w_snap ? r_dp_mask  : r_sh_dp_mask;

    // w_nz_from[k]: some nibble in k..7 is non-zero
    always_comb begin
        w_nz_from    = '0;
        w_nz_from[7] = |w_val_src[31:28];
        for (int k = 6; k >= 0; k--) begin
            w_nz_from[k] = w_nz_from[k+1] | (|w_val_src[k*4 +: 4]);
        end
    end

    assign w_nib = w_val_src[{w_idx_nxt, 2'b00} +: 4];
    assign w_lit = w_en_src[w_idx_nxt] &&
                   !(w_lz_src && (w_idx_nxt != 3'd0) && !w_nz_from[w_idx_nxt]);

    always_comb begin
        w_an_nxt   = AN_OFF;
        w_seg_nxt  = SEG_OFF;
        w_dp_n_nxt = 1'b1;
        if ((w_state_nxt == S_DRIVE) && w_lit) begin
            w_an_nxt   = ~(8'd1 << w_idx_nxt);
            w_seg_nxt  = ~hex_code(w_nib);
            w_dp_n_nxt = ~w_dp_src[w_idx_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an   <= AN_OFF;
            r_seg  <= SEG_OFF;
            r_dp_n <= 1'b1;
        end else begin
            r_an   <= w_an_nxt;
            r_seg  <= w_seg_nxt;
            r_dp_n <= w_dp_n_nxt;
        end
    end

    assign rdata = r_rdata;
    assign an    = r_an;
    assign seg   = r_seg;
    assign dp_n  = r_dp_n;

endmodule
